// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 (x^31 + x^28 + 1) link checker: fills, acquires, locks,
// then counts bit errors against a free-running local reference until an error burst.
module prbs31_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int UNLOCK_WIN  = 256,
  parameter int UNLOCK_ERRS = 8,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int WIN_W = $clog2(UNLOCK_WIN);
  localparam int WE_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [7:0]       MATCH_TARGET = 8'(LOCK_COUNT);
  localparam logic [WIN_W-1:0] WIN_LAST     = WIN_W'(UNLOCK_WIN - 1);
  localparam logic [WE_W-1:0]  ERRS_LIMIT   = WE_W'(UNLOCK_ERRS);
  localparam logic [ERR_W-1:0] ERR_MAX      = '1;

  state_t           r_state;
  logic [30:0]      r_h;
  logic [4:0]       r_fill_cnt;
  logic [7:0]       r_match_cnt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [WE_W-1:0]  r_win_errs;
  logic [ERR_W-1:0] r_err_count;
  logic             r_err_pulse;
  logic             r_locked;

  logic             w_pred;
  logic             w_mismatch;
  logic             w_h_zero;
  logic [7:0]       w_match_next;
  logic [WE_W-1:0]  w_win_errs_next;
  logic             w_win_wrap;

  assign w_pred          = r_h[27] ^ r_h[30];
  assign w_mismatch      = din ^ w_pred;
  // An all-zero history predicts zero forever; refusing to match it keeps stuck-at-0 from locking.
  assign w_h_zero        = (r_h == '0);
  assign w_match_next    = r_match_cnt + 8'd1;
  assign w_win_errs_next = r_win_errs + WE_W'(w_mismatch);
  assign w_win_wrap      = (r_win_cnt == WIN_LAST);

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; reset is tested inside the clocked block, making it synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_h         <= '0;
      r_fill_cnt  <= '0;
      r_match_cnt <= '0;
      r_win_cnt   <= '0;
      r_win_errs  <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      if (clr_cnt) r_err_count <= '0;
      if (en) begin
        case (r_state)
          FILL: begin
            r_h        <= {r_h[29:0], din};
            r_fill_cnt <= r_fill_cnt + 5'd1;
            if (r_fill_cnt == 5'd30) begin
              r_state     <= ACQ;
              r_match_cnt <= '0;
            end
          end
          ACQ: begin
            r_h <= {r_h[29:0], din};
            if (!w_mismatch && !w_h_zero) begin
              r_match_cnt <= w_match_next;
              if (w_match_next == MATCH_TARGET) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_win_cnt  <= '0;
                r_win_errs <= '0;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Feeding back the prediction keeps one flipped bit from corrupting later predictions.
            r_h <= {r_h[29:0], w_pred};
            if (w_mismatch) begin
              r_err_pulse <= 1'b1;
              if (!clr_cnt && r_err_count != ERR_MAX) r_err_count <= r_err_count + ERR_W'(1);
            end
            r_win_cnt  <= w_win_wrap ? '0 : r_win_cnt + WIN_W'(1);
            r_win_errs <= w_win_wrap ? '0 : w_win_errs_next;
            if (w_win_errs_next == ERRS_LIMIT) begin
              r_state     <= FILL;
              r_locked    <= 1'b0;
              r_fill_cnt  <= '0;
              r_match_cnt <= '0;
            end
          end
          default: begin
            r_state  <= FILL;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: scenario table plus hand sequences, every cycle compared
// against a queue-based model of the checker's rules.
module tb_prbs31_checker;

  localparam int LOCK_COUNT  = 64;
  localparam int UNLOCK_WIN  = 256;
  localparam int UNLOCK_ERRS = 8;

  logic        clk = 1'b0;
  logic        rst_n, en, din, clr_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        locked3, err_pulse3;
  logic [2:0]  err_count3;
  logic [1:0]  state3;

  always #5 clk = ~clk;

  prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
  );

  prbs31_checker #(.ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr_cnt(clr_cnt),
    .locked(locked3), .err_pulse(err_pulse3), .err_count(err_count3), .state(state3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus source: the team generator, seeded with 1.
  bit [30:0] g_reg;
  function automatic bit gen_next();
    bit b;
    b     = g_reg[27] ^ g_reg[30];
    g_reg = {g_reg[29:0], b};
    return b;
  endfunction

  // Reference model: last 31 accepted bits in a queue (oldest first), counts as plain ints.
  localparam int M_FILL = 0, M_ACQ = 1, M_LOCK = 2;
  int m_mode, m_fill, m_match, m_win, m_werr, m_raw;
  bit m_pulse;
  bit m_hist[$];

  function automatic void model_reset();
    m_mode = M_FILL; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_raw = 0; m_pulse = 0;
    m_hist.delete();
    repeat (31) m_hist.push_back(1'b0);
  endfunction

  function automatic void model_push(bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic void model_step(bit r_n, bit e, bit d, bit c);
    bit p, all_zero;
    if (!r_n) begin
      model_reset();
      return;
    end
    m_pulse = 0;
    if (c) m_raw = 0;
    if (!e) return;
    p = m_hist[m_hist.size() - 28] ^ m_hist[m_hist.size() - 31];
    all_zero = 1;
    foreach (m_hist[i]) if (m_hist[i]) all_zero = 0;
    case (m_mode)
      M_FILL: begin
        model_push(d);
        m_fill++;
        if (m_fill == 31) begin m_mode = M_ACQ; m_match = 0; end
      end
      M_ACQ: begin
        model_push(d);
        if (d == p && !all_zero) m_match++;
        else m_match = 0;
        if (m_match == LOCK_COUNT) begin m_mode = M_LOCK; m_win = 0; m_werr = 0; end
      end
      default: begin
        model_push(p);
        if (d != p) begin
          m_pulse = 1;
          if (!c) m_raw++;
          m_werr++;
        end
        m_win++;
        if (m_werr == UNLOCK_ERRS) begin
          m_mode = M_FILL; m_fill = 0; m_match = 0;
        end else if (m_win == UNLOCK_WIN) begin
          m_win = 0; m_werr = 0;
        end
      end
    endcase
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One clock: drive, model the edge, then compare both instances 1 time unit later.
  task automatic cycle(input bit r_n, input bit e, input bit d, input bit c);
    rst_n = r_n; en = e; din = d; clr_cnt = c;
    @(posedge clk);
    model_step(r_n, e, d, c);
    #1;
    check("locked", locked, (m_mode == M_LOCK));
    check("err_pulse", err_pulse, m_pulse);
    check("err_count", err_count, sat(m_raw, 65535));
    check("state", state, m_mode);
    check("err_count_w3", err_count3, sat(m_raw, 7));
  endtask

  typedef struct {
    string name;
    bit    do_reset;
    int    n_valid;
    int    en_pct;
    int    src;         // 0 PRBS, 1 stuck-at-0, 2 stuck-at-1
    int    flip_every;  // invert every Nth valid bit, 0 = none
    int    exp_state;
    int    exp_locked;
    int    exp_cnt;
    int    exp_cnt3;
  } vec_t;

  vec_t vec[14];

  task automatic run_row(input vec_t v);
    int sent;
    bit e, b;
    if (v.do_reset) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      g_reg = 31'd1;
    end
    sent = 0;
    while (sent < v.n_valid) begin
      e = ($urandom_range(99) < v.en_pct);
      if (e) begin
        case (v.src)
          1:       b = 1'b0;
          2:       b = 1'b1;
          default: b = gen_next();
        endcase
        if (v.flip_every != 0 && (sent + 1) % v.flip_every == 0) b = ~b;
        sent++;
      end else begin
        b = 1'($urandom_range(1));
      end
      cycle(1'b1, e, b, 1'b0);
    end
    check({v.name, ":state"}, state, v.exp_state);
    check({v.name, ":locked"}, locked, v.exp_locked);
    check({v.name, ":err_count"}, err_count, v.exp_cnt);
    check({v.name, ":err_count_w3"}, err_count3, v.exp_cnt3);
  endtask

  task automatic hand_sequences();
    bit b;
    // Error and clear on the same edge: pulse fires, count ends at zero.
    b = gen_next();
    cycle(1'b1, 1'b1, ~b, 1'b1);
    check("clr_err:pulse", err_pulse, 1);
    check("clr_err:count", err_count, 0);
    check("clr_err:count3", err_count3, 0);
    b = gen_next();
    cycle(1'b1, 1'b1, ~b, 1'b0);
    check("after_clr:pulse", err_pulse, 1);
    check("after_clr:count", err_count, 1);
    // Idle cycle: pulse drops, everything holds.
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("idle:pulse", err_pulse, 0);
    check("idle:count", err_count, 1);
    check("idle:locked", locked, 1);
    // Reset mid-LOCKED with an erroneous bit presented.
    b = gen_next();
    cycle(1'b0, 1'b1, ~b, 1'b0);
    check("rst_locked:locked", locked, 0);
    check("rst_locked:pulse", err_pulse, 0);
    check("rst_locked:count", err_count, 0);
    check("rst_locked:state", state, 0);
    check("rst_locked:count3", err_count3, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    g_reg = 31'd1;
    model_reset();

    vec[0]  = '{"fill_acq",   1'b1,   94, 100, 0,    0, 1, 0,  0, 0};
    vec[1]  = '{"lock95",     1'b0,    1, 100, 0,    0, 2, 1,  0, 0};
    vec[2]  = '{"clean10k",   1'b0, 9905, 100, 0,    0, 2, 1,  0, 0};
    vec[3]  = '{"single_err", 1'b0, 1000, 100, 0, 1000, 2, 1,  1, 1};
    vec[4]  = '{"win_pass",   1'b0,  256, 100, 0,    0, 2, 1,  1, 1};
    vec[5]  = '{"burst8",     1'b0,   80, 100, 0,   10, 0, 0,  9, 7};
    vec[6]  = '{"refill",     1'b0,   94, 100, 0,    0, 1, 0,  9, 7};
    vec[7]  = '{"relock",     1'b0,    1, 100, 0,    0, 2, 1,  9, 7};
    vec[8]  = '{"spread10",   1'b0, 3000, 100, 0,  300, 2, 1, 19, 7};
    vec[9]  = '{"stuck0",     1'b1, 1000, 100, 1,    0, 1, 0,  0, 0};
    vec[10] = '{"stuck1",     1'b1, 1000, 100, 2,    0, 1, 0,  0, 0};
    vec[11] = '{"gap_acq",    1'b1,   94,  50, 0,    0, 1, 0,  0, 0};
    vec[12] = '{"gap_lock",   1'b0,    1,  50, 0,    0, 2, 1,  0, 0};
    vec[13] = '{"gap_errs",   1'b0, 2000,  50, 0,  700, 2, 1,  2, 2};

    for (int k = 0; k < 14; k++) begin
      if (k == 9) hand_sequences();
      run_row(vec[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
